truth_table_sweep: RTL and testbench

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

---
 rtl/truth_table_sweep.sv | 98 +++++++++
 tb/tb_truth_table_sweep.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep.sv
// Truth-table sweeper: drives {x,y,z} through 0..7, holds each vector SETTLE_CYCLES+1 cycles, captures f.
// Optional compare against an expected table is enabled by defining TT_COMPARE_EN.
module truth_table_sweep #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
`ifdef TT_COMPARE_EN
    input  logic [7:0] expected,
    output logic       mismatch,
`endif
    output logic [7:0] truth_table
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [2:0] index;
    logic [3:0] settle;
    logic [7:0] table_next;

    // Table as it will look once the current vector's response is written.
    always_comb begin
        table_next        = truth_table;
        table_next[index] = f;
    end

    assign {x, y, z} = index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            index       <= 3'd0;
            settle      <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 8'h00;
`ifdef TT_COMPARE_EN
            mismatch    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SWEEP;
                        index       <= 3'd0;
                        settle      <= 4'd0;
                        busy        <= 1'b1;
                        truth_table <= 8'h00;
`ifdef TT_COMPARE_EN
                        mismatch    <= 1'b0;
`endif
                    end
                end
                SWEEP: begin
                    if (settle == SETTLE_LAST) begin
                        truth_table <= table_next;
                        settle      <= 4'd0;
                        if (index == 3'd7) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
`ifdef TT_COMPARE_EN
                            mismatch <= (table_next != expected);
`endif
                        end else begin
                            index <= index + 3'd1;
                        end
                    end else begin
                        settle <= settle + 4'd1;
                    end
                end
                DONE: begin
                    // Index returns to 0 here so the drive vector is 000 throughout IDLE.
                    state <= IDLE;
                    done  <= 1'b0;
                    index <= 3'd0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    index <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench for truth_table_sweep: dut 0 uses SETTLE_CYCLES=0, dut 1 uses SETTLE_CYCLES=1.
module tb_truth_table_sweep;

    typedef struct {
        logic [7:0] tt;
        logic       mm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, f, x, y, z, busy, done, mm;
    logic [7:0] tt   [2];
    logic [7:0] cut  [2];
    logic [7:0] expv [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Circuits under sweep: arbitrary 3-input functions given as truth tables.
    assign f[0] = cut[0][{x[0], y[0], z[0]}];
    assign f[1] = cut[1][{x[1], y[1], z[1]}];

    truth_table_sweep #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .f(f[0]),
        .x(x[0]), .y(y[0]), .z(z[0]), .busy(busy[0]), .done(done[0]),
`ifdef TT_COMPARE_EN
        .expected(expv[0]), .mismatch(mm[0]),
`endif
        .truth_table(tt[0])
    );

    truth_table_sweep #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .f(f[1]),
        .x(x[1]), .y(y[1]), .z(z[1]), .busy(busy[1]), .done(done[1]),
`ifdef TT_COMPARE_EN
        .expected(expv[1]), .mismatch(mm[1]),
`endif
        .truth_table(tt[1])
    );

`ifndef TT_COMPARE_EN
    assign mm = 2'b00;
`endif

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[dut%0d]: got %0h, expected %0h at %0t", name, d, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input int d);
        n_cmp++;
        n_bad++;
        $display("FAIL %s[dut%0d]: got event, expected none at %0t", name, d, $time);
    endtask

    function automatic exp_t model(input int d);
        exp_t e;
        e.tt = cut[d];
`ifdef TT_COMPARE_EN
        e.mm = (cut[d] != expv[d]);
`else
        e.mm = 1'b0;
`endif
        return e;
    endfunction

    task automatic push(input int d);
        if (d == 0) q0.push_back(model(0));
        else        q1.push_back(model(1));
    endtask

    task automatic start_dut(input int d);
        @(posedge clk); #1;
        start[d] = 1'b1;
        push(d);
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic start_both();
        @(posedge clk); #1;
        start = 2'b11;
        push(0);
        push(1);
        @(posedge clk); #1;
        start = 2'b00;
    endtask

    task automatic wait_done(input int d, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[d] && n < limit);
        check("done_timeout", d, {31'd0, done[d]}, 32'd1);
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks sequencing every cycle.
    initial begin
        int   bcnt [2];
        logic pbusy [2];
        logic pdone [2];
        logic [7:0] last_tt [2];
        logic last_mm [2];
        exp_t e;
        bit   empty;
        for (int d = 0; d < 2; d++) begin
            bcnt[d] = 0; pbusy[d] = 0; pdone[d] = 0; last_tt[d] = 0; last_mm[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int per;
                per = (d == 0) ? 1 : 2;
                if (rst) begin
                    bcnt[d] = 0; pbusy[d] = 0; pdone[d] = 0; last_tt[d] = 0; last_mm[d] = 0;
                    continue;
                end
                if (busy[d]) begin
                    if (bcnt[d] == 0) check("table_cleared", d, {24'd0, tt[d]}, 32'd0);
                    check("xyz_step", d, {29'd0, x[d], y[d], z[d]}, (bcnt[d] / per) % 8);
                    check("done_while_busy", d, {31'd0, done[d]}, 32'd0);
                    check("mismatch_cleared", d, {31'd0, mm[d]}, 32'd0);
                    bcnt[d]++;
                end else begin
                    if (pbusy[d]) begin
                        check("busy_len", d, bcnt[d], 8 * per);
                        check("done_after_busy", d, {31'd0, done[d]}, 32'd1);
                    end
                    bcnt[d] = 0;
                    if (done[d]) begin
                        check("done_single", d, {31'd0, pdone[d]}, 32'd0);
                        empty = 1'b0;
                        if (d == 0) begin
                            if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
                        end else begin
                            if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
                        end
                        if (empty) fail_now("spurious_done", d);
                        else begin
                            check("table", d, {24'd0, tt[d]}, {24'd0, e.tt});
                            check("mismatch", d, {31'd0, mm[d]}, {31'd0, e.mm});
                        end
                        last_tt[d] = tt[d];
                        last_mm[d] = mm[d];
                    end else begin
                        check("idle_xyz", d, {29'd0, x[d], y[d], z[d]}, 32'd0);
                        check("table_hold", d, {24'd0, tt[d]}, {24'd0, last_tt[d]});
                        check("mismatch_hold", d, {31'd0, mm[d]}, {31'd0, last_mm[d]});
                    end
                end
                pbusy[d] = busy[d];
                pdone[d] = done[d];
            end
        end
    end

    initial begin
        bit seen;
        rst   = 1'b1;
        start = 2'b00;
        cut[0] = 8'h00; cut[1] = 8'h00;
        expv[0] = 8'h00; expv[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_busy", d, {31'd0, busy[d]}, 32'd0);
            check("reset_done", d, {31'd0, done[d]}, 32'd0);
            check("reset_table", d, {24'd0, tt[d]}, 32'd0);
            check("reset_xyz", d, {29'd0, x[d], y[d], z[d]}, 32'd0);
            check("reset_mismatch", d, {31'd0, mm[d]}, 32'd0);
        end

        // Parity with one settle cycle, then AND3 with no settle.
        cut[1] = 8'h96; expv[1] = 8'h96;
        start_dut(1);
        wait_done(1, 40);
        cut[0] = 8'h80; expv[0] = 8'h80;
        start_dut(0);
        wait_done(0, 20);

        // Compare feature: wrong expectation flags, next start clears it.
        cut[1] = 8'h96; expv[1] = 8'h97;
        start_dut(1);
        wait_done(1, 40);
        expv[1] = 8'h96;
        start_dut(1);
        wait_done(1, 40);

        // Start pulses during SWEEP and during DONE are ignored.
        cut[1] = 8'($urandom); expv[1] = cut[1];
        start_dut(1);
        repeat (5) @(posedge clk);
        #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        wait_done(1, 40);
        start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy[1]) seen = 1'b1;
        end
        check("no_restart", 1, {31'd0, seen}, 32'd0);

        // Reset while index is 4 abandons the sweep.
        cut[1] = 8'h96; expv[1] = 8'h96;
        start_dut(1);
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if ({x[1], y[1], z[1]} == 3'd4) break;
        end
        check("reached_index4", 1, {29'd0, x[1], y[1], z[1]}, 32'd4);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 1, {31'd0, busy[1]}, 32'd0);
        check("midrst_done", 1, {31'd0, done[1]}, 32'd0);
        check("midrst_table", 1, {24'd0, tt[1]}, 32'd0);
        check("midrst_xyz", 1, {29'd0, x[1], y[1], z[1]}, 32'd0);
        start_dut(1);
        wait_done(1, 40);

        // Random functions on both sweepers concurrently.
        repeat (8) begin
            for (int d = 0; d < 2; d++) begin
                cut[d]  = 8'($urandom);
                expv[d] = ($urandom_range(0, 1) == 1) ? cut[d] : 8'($urandom);
            end
            start_both();
            wait_done(0, 20);
            wait_done(1, 40);
        end

        // Start held high: back-to-back sweeps with one IDLE cycle between.
        cut[1] = 8'($urandom); expv[1] = cut[1];
        push(1); push(1); push(1);
        @(posedge clk); #1 start[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(1, 40);
            if (k < 2) begin
                @(negedge clk);
                check("gap_idle", 1, {30'd0, busy[1], done[1]}, 32'd0);
                @(negedge clk);
                check("gap_busy", 1, {31'd0, busy[1]}, 32'd1);
            end else begin
                start[1] = 1'b0;
            end
        end

        repeat (20) @(negedge clk);
        check("queue_drained", 0, q0.size(), 32'd0);
        check("queue_drained", 1, q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
